// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive frame-capture block.
package udp_rx_pkg;

  localparam int BYTE_W        = 8;
  localparam int LEN_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_SYNC = 2'b00,
    ST_IDLE = 2'b01,
    ST_RECV = 2'b10,
    ST_DROP = 2'b11
  } state_e;

endpackage

// File: rtl/udp_rx_shift_buf.sv
// Work buffer for one frame: cleared and loaded by the first byte, then
// shifted (or held once full in keep-first mode). Tracks a saturating count.
module udp_rx_shift_buf
  import udp_rx_pkg::*;
#(
  parameter int DEPTH     = 160,
  parameter int KEEP_LAST = 1,
  parameter int LEN_W     = LEN_W_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    load_first_i,
  input  logic                    shift_i,
  input  logic [BYTE_W-1:0]       byte_i,
  output logic [BYTE_W*DEPTH-1:0] work_o,
  output logic [LEN_W-1:0]        cnt_o
);

  localparam int               BUF_W   = BYTE_W * DEPTH;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [BUF_W-1:0] work_q, work_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  // Next buffer/count: first byte restarts the frame, later bytes shift or hold.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    if (load_first_i) begin
      work_d = {{(BUF_W-BYTE_W){1'b0}}, byte_i};
      cnt_d  = ONE_L;
    end else if (shift_i) begin
      if ((KEEP_LAST != 0) || (cnt_q < DEPTH_L)) begin
        work_d = {work_q[BUF_W-BYTE_W-1:0], byte_i};
      end else begin
        work_d = work_q;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + ONE_L;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      work_d = work_q;
      cnt_d  = cnt_q;
    end
  end

  // Buffer and count state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
    end
  end

  assign work_o = work_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/udp_rx_capture.sv
// Captures UDP payload bytes per frame and publishes a stable snapshot,
// length, overflow flag and done strobe when the frame ends.
module udp_rx_capture
  import udp_rx_pkg::*;
#(
  parameter int DEPTH     = 160,
  parameter int KEEP_LAST = 1,
  parameter int LEN_W     = LEN_W_DEFAULT
) (
  input  logic                    rgmii_clk,
  input  logic                    rstn,
  input  logic                    capture_en,
  input  logic                    udp_rec_data_valid,
  input  logic [BYTE_W-1:0]       udp_rec_rdata,
  output logic [BYTE_W*DEPTH-1:0] rx_data,
  output logic [LEN_W-1:0]        rx_len,
  output logic                    rx_ovf,
  output logic                    rx_done,
  output logic [LEN_W-1:0]        frame_cnt,
  output logic                    busy
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e                    state_q;
  logic [BYTE_W*DEPTH-1:0]   rx_data_q;
  logic [LEN_W-1:0]          rx_len_q;
  logic                      rx_ovf_q;
  logic                      rx_done_q;
  logic [LEN_W-1:0]          frame_cnt_q;
  logic                      busy_q;

  logic [BYTE_W*DEPTH-1:0]   work_data_s;
  logic [LEN_W-1:0]          work_cnt_s;
  logic                      load_first_s;
  logic                      shift_s;

  // First byte of an accepted frame restarts the buffer; later bytes feed it.
  assign load_first_s = (state_q == ST_IDLE) && udp_rec_data_valid && capture_en;
  assign shift_s      = (state_q == ST_RECV) && udp_rec_data_valid;

  udp_rx_shift_buf #(
    .DEPTH    (DEPTH),
    .KEEP_LAST(KEEP_LAST),
    .LEN_W    (LEN_W)
  ) u_shift_buf (
    .clk_i       (rgmii_clk),
    .rstn_i      (rstn),
    .load_first_i(load_first_s),
    .shift_i     (shift_s),
    .byte_i      (udp_rec_rdata),
    .work_o      (work_data_s),
    .cnt_o       (work_cnt_s)
  );

  // Frame FSM with registered busy, publish registers and frame counter.
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_SYNC;
      rx_data_q   <= '0;
      rx_len_q    <= '0;
      rx_ovf_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          // Wait out any frame already running when reset was released.
          if (!udp_rec_data_valid) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_SYNC;
          end
          busy_q <= 1'b0;
        end
        ST_IDLE: begin
          if (udp_rec_data_valid) begin
            state_q <= capture_en ? ST_RECV : ST_DROP;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RECV: begin
          if (!udp_rec_data_valid) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            rx_data_q   <= work_data_s;
            rx_len_q    <= work_cnt_s;
            rx_ovf_q    <= (work_cnt_s > DEPTH_L);
            rx_done_q   <= 1'b1;
            frame_cnt_q <= frame_cnt_q + ONE_L;
          end else begin
            state_q <= ST_RECV;
            busy_q  <= 1'b1;
          end
        end
        ST_DROP: begin
          if (!udp_rec_data_valid) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_DROP;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_SYNC;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_len    = rx_len_q;
  assign rx_ovf    = rx_ovf_q;
  assign rx_done   = rx_done_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_udp_rx_capture.sv
// Scoreboard bench: two DEPTH=4 instances (keep-last and keep-first) share
// one stimulus stream; expected snapshots are queued per frame and compared
// on each rx_done strobe.
module tb_udp_rx_capture;

  localparam int DEPTH = 4;
  localparam int LW    = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] len;
    logic        ovf;
    logic [15:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, capture_en, valid;
  logic [7:0]    rdata;
  logic [31:0]   a_data, b_data;
  logic [LW-1:0] a_len, b_len, a_fc, b_fc;
  logic          a_ovf, b_ovf, a_done, b_done, a_busy, b_busy;

  exp_t        q_last[$];
  exp_t        q_first[$];
  exp_t        last_a, last_b;
  logic [15:0] exp_fcnt;
  logic [7:0]  fr[$];
  int          checks   = 0;
  int          failures = 0;

  udp_rx_capture #(.DEPTH(DEPTH), .KEEP_LAST(1), .LEN_W(LW)) u_last (
    .rgmii_clk(clk), .rstn(rstn), .capture_en(capture_en),
    .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
    .rx_data(a_data), .rx_len(a_len), .rx_ovf(a_ovf), .rx_done(a_done),
    .frame_cnt(a_fc), .busy(a_busy)
  );

  udp_rx_capture #(.DEPTH(DEPTH), .KEEP_LAST(0), .LEN_W(LW)) u_first (
    .rgmii_clk(clk), .rstn(rstn), .capture_en(capture_en),
    .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
    .rx_data(b_data), .rx_len(b_len), .rx_ovf(b_ovf), .rx_done(b_done),
    .frame_cnt(b_fc), .busy(b_busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected snapshot: byte k (from the LSB) is the k-th newest retained byte.
  function automatic logic [31:0] model(input logic [7:0] b[$], input bit keep_last);
    logic [31:0] d;
    int n, m;
    d = 32'h0;
    n = b.size();
    m = (n < DEPTH) ? n : DEPTH;
    for (int k = 0; k < m; k++) begin
      if (keep_last) d[8*k +: 8] = b[n-1-k];
      else           d[8*k +: 8] = b[m-1-k];
    end
    return d;
  endfunction

  // Monitor for the keep-last instance.
  always @(negedge clk) begin : mon_last
    exp_t e;
    if (a_done === 1'b1) begin
      check_val("last_done_pending", 64'(q_last.size() > 0), 64'd1);
      if (q_last.size() > 0) begin
        e = q_last.pop_front();
        check_val("last_data", 64'(a_data), 64'(e.data));
        check_val("last_len",  64'(a_len),  64'(e.len));
        check_val("last_ovf",  64'(a_ovf),  64'(e.ovf));
        check_val("last_fcnt", 64'(a_fc),   64'(e.fcnt));
      end
    end
  end

  // Monitor for the keep-first instance.
  always @(negedge clk) begin : mon_first
    exp_t e;
    if (b_done === 1'b1) begin
      check_val("first_done_pending", 64'(q_first.size() > 0), 64'd1);
      if (q_first.size() > 0) begin
        e = q_first.pop_front();
        check_val("first_data", 64'(b_data), 64'(e.data));
        check_val("first_len",  64'(b_len),  64'(e.len));
        check_val("first_ovf",  64'(b_ovf),  64'(e.ovf));
        check_val("first_fcnt", 64'(b_fc),   64'(e.fcnt));
      end
    end
  end

  task automatic send_frame(input logic [7:0] b[$], input bit cap, input int gap);
    exp_t ea, eb;
    if (cap) begin
      exp_fcnt = exp_fcnt + 16'd1;
      ea.data = model(b, 1'b1);
      ea.len  = 16'(b.size());
      ea.ovf  = (b.size() > DEPTH);
      ea.fcnt = exp_fcnt;
      eb      = ea;
      eb.data = model(b, 1'b0);
      q_last.push_back(ea);
      q_first.push_back(eb);
      last_a = ea;
      last_b = eb;
    end
    for (int i = 0; i < b.size(); i++) begin
      valid      = 1'b1;
      rdata      = b[i];
      capture_en = (i == 0) ? cap : ~cap;
      @(posedge clk); #1;
      if (i == 0) begin
        check_val("busy_start_last",  64'(a_busy), 64'd1);
        check_val("busy_start_first", 64'(b_busy), 64'd1);
      end
    end
    valid      = 1'b0;
    rdata      = 8'h00;
    capture_en = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      if (g == 0) check_val("busy_end", 64'(a_busy | b_busy), 64'd0);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (q_last.size() + q_first.size()) != 0; i++) @(negedge clk);
    check_val(tag, 64'(q_last.size() + q_first.size()), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; valid = 1'b0; capture_en = 1'b1; rdata = 8'h00; exp_fcnt = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_data",  64'(a_data | b_data), 64'd0);
    check_val("rst_len",   64'(a_len | b_len),   64'd0);
    check_val("rst_flags", 64'({a_ovf, b_ovf, a_done, b_done, a_busy, b_busy}), 64'd0);
    check_val("rst_fcnt",  64'(a_fc | b_fc),     64'd0);

    // Frame already in flight when reset is released: must be discarded.
    valid = 1'b1; rdata = 8'h55;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdata = 8'h60 + 8'(i);
      @(posedge clk); #1;
    end
    check_val("sync_busy", 64'(a_busy | b_busy), 64'd0);
    valid = 1'b0;
    @(posedge clk); #1;
    fr.delete(); fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
    send_frame(fr, 1'b1, 3);
    drain("drain_sync");

    // Overflow 01..06, exact DEPTH, DEPTH+1.
    fr.delete(); for (int i = 1; i <= 6; i++) fr.push_back(8'(i));
    send_frame(fr, 1'b1, 2);
    fr.delete(); for (int i = 0; i < 4; i++) fr.push_back(8'h9A + 8'(i));
    send_frame(fr, 1'b1, 2);
    fr.delete(); for (int i = 0; i < 5; i++) fr.push_back(8'h40 + 8'(i));
    send_frame(fr, 1'b1, 2);
    drain("drain_ovf");

    // Back-to-back frames with a 1-cycle gap.
    fr.delete(); for (int i = 0; i < 4; i++) fr.push_back(8'hAA);
    send_frame(fr, 1'b1, 1);
    fr.delete(); for (int i = 0; i < 2; i++) fr.push_back(8'hBB);
    send_frame(fr, 1'b1, 3);
    drain("drain_b2b");

    // Dropped frame: capture_en low at first byte, raised mid-frame.
    fr.delete(); fr.push_back(8'hC0); fr.push_back(8'hC1);
    send_frame(fr, 1'b0, 4);
    check_val("drop_data_last",  64'(a_data), 64'(last_a.data));
    check_val("drop_data_first", 64'(b_data), 64'(last_b.data));
    check_val("drop_fcnt",       64'(a_fc),   64'(last_a.fcnt));
    drain("drain_drop");

    // Reset in the middle of a frame.
    valid = 1'b1; rdata = 8'h71;
    @(posedge clk); #1;
    rdata = 8'h72;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check_val("mid_rst_data",  64'(a_data | b_data), 64'd0);
    check_val("mid_rst_len",   64'(a_len | b_len),   64'd0);
    check_val("mid_rst_flags", 64'({a_ovf, b_ovf, a_done, b_done, a_busy, b_busy}), 64'd0);
    check_val("mid_rst_fcnt",  64'(a_fc | b_fc),     64'd0);
    exp_fcnt = 16'd0;
    @(posedge clk); #1;
    rstn = 1'b1; rdata = 8'h73;
    @(posedge clk); #1;
    rdata = 8'h74;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    fr.delete(); fr.push_back(8'h7E);
    send_frame(fr, 1'b1, 3);
    drain("drain_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
